register_unit_burst: RTL and testbench
======================================

Name: register_unit_burst

Overview:
- Parametrised successor of the two-register A/B shift unit used by the serial multiplier datapath.
- Holds two WIDTH-bit registers, A and B, each loadable from a common data bus.
- Registers can be chained into one 2*WIDTH shift path or operated independently.
- Adds four shift modes and an autonomous burst-shift sequencer (Start/Count, Busy/Done), so the control FSM no longer issues every shift step.

Parameters:
- WIDTH, 8, bit width of each of A and B (WIDTH >= 2).
- CHAIN, 1, 1 = A and B form one path {A,B}; 0 = A and B shift independently.
- CW, $clog2(WIDTH*2+1), width of the burst Count input.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset; sampled on rising Clk edge.
- Ld_A  input  1  load A from D.
- Ld_B  input  1  load B from D.
- D  input  WIDTH  parallel load data.
- Shift_En  input  1  single shift step when idle.
- Start  input  1  begin burst of Count shifts; sampled in IDLE only.
- Count  input  CW  burst length, captured at Start.
- Mode  input  2  00 logical right, 01 arithmetic right, 10 rotate right, 11 logical left.
- A_In  input  1  serial bit entering A MSB on right shifts.
- B_In  input  1  serial bit entering B LSB on left shifts; entering B MSB on right shifts when CHAIN=0.
- A_out  output  1  A[0], combinational.
- B_out  output  1  B[0], combinational.
- A  output  WIDTH  register A.
- B  output  WIDTH  register B.
- Busy  output  1  high while burst in progress.
- Done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (Reset=0 at edge):
  - A=0, B=0, Busy=0, Done=0.
  - FSM to IDLE, counter=0, captured mode=00.
  - Reset overrides everything, including mid-burst.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, Start=1, Count!=0: capture Count and Mode, go to SHIFT. The first shift occurs on the next edge.
  - IDLE, Start=1, Count=0: go directly to DONE with no shift.
  - SHIFT: one shift per cycle using the captured Mode; counter decrements; after the shift where counter==1, go to DONE.
  - DONE: Done=1 for exactly one cycle, then IDLE.
  - Busy=1 in SHIFT and DONE.
  - Latency from Start to Done = Count+1 cycles.
- Priority in IDLE: Start > Ld_A/Ld_B > Shift_En.
  - Ld_A and Ld_B may be asserted together; both load D.
  - Loads in the same cycle as Start are ignored.
- During Busy: Ld_A, Ld_B, Shift_En and Start are ignored. Mode and input changes do not affect an active burst.
- Right shift, CHAIN=1:
  - A <= {msb, A[W-1:1]}; B <= {A[0], B[W-1:1]}.
  - msb = A_In (00), A[W-1] (01), B[0] (10), 0 (11 n/a).
- Left shift (11), CHAIN=1: A <= {A[W-2:0], B[W-1]}; B <= {B[W-2:0], B_In}.
- CHAIN=0, right shifts: each register shifts alone.
  - A msb = A_In / A[W-1] / A[0] for modes 00/01/10.
  - B msb = B_In / B[W-1] / B[0] for modes 00/01/10.
- CHAIN=0, left shift: A gets A_In at LSB; B gets B_In at LSB.
- Serial inputs A_In/B_In are sampled live each burst cycle; only Mode is captured.
- Count > 2*WIDTH is legal: the shift simply continues, wrapping for rotate and saturating to fill bits otherwise.
- A_out, B_out, A and B reflect register state; Busy and Done are registered.

Test Plan:
- Reset=0 for 2 cycles with random inputs, then release -> A=0x00, B=0x00, Busy=0, Done=0.
- WIDTH=8, CHAIN=1: load A=0x81, B=0x00; Start, Count=4, Mode=01 -> after 4 shifts A=0xF8, B=0x10. Busy high for 5 cycles; Done pulses on cycle 5.
- Load A=0x12, B=0x34; Start, Count=16, Mode=10 -> A=0x12, B=0x34 restored; Done pulses once.
- Idle Shift_En with Mode=11, B_In=1 from A=0x00, B=0x80 -> A=0x01, B=0x01. Next step with Ld_A=1, D=0x55 and Shift_En=1 -> A=0x55, B unchanged.
- Start with Count=0 -> no register change; Done high on the next cycle; Busy high for exactly one cycle.
- Mid-burst (cycle 3 of Count=8): assert Ld_A with D=0xFF -> ignored. Then assert Reset=0 -> A=B=0, IDLE, no Done pulse.
- CHAIN=0, Mode=00, A_In=1, B_In=0, A=0x00, B=0xFF, Count=2 -> A=0xC0, B=0x3F.

Source files
------------

// File: rtl/register_unit_burst.sv
// register_unit_burst
//   Two WIDTH-bit registers A and B, loadable from a common bus D, with four
//   shift modes and an autonomous burst-shift sequencer.
//   When CHAIN=1, A and B form one 2*WIDTH path {A,B}. When CHAIN=0, they
//   shift independently.
//
// Ports
//   Clk              rising-edge clock
//   Reset            synchronous active-low reset
//   Ld_A, Ld_B, D    parallel loads while idle (both may load together)
//   Shift_En         single shift step while idle, using the live Mode
//   Start, Count     start a burst of Count shifts using the Mode captured at Start
//   Mode             00 logical right, 01 arithmetic right, 10 rotate right,
//                    11 logical left
//   A_In, B_In       serial inputs, sampled live on every shift
//   A_out, B_out     LSBs of A and B
//   A, B             register contents
//   Busy, Done       burst in progress / one-cycle completion pulse (registered)
module register_unit_burst #(
  parameter int WIDTH = 8,
  parameter int CHAIN = 1,
  parameter int CW    = $clog2(WIDTH*2+1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Ld_A,
  input  logic             Ld_B,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CW-1:0]    Count,
  input  logic [1:0]       Mode,
  input  logic             A_In,
  input  logic             B_In,
  output logic             A_out,
  output logic             B_out,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*WIDTH-1:0] burst_step_s;
  logic [2*WIDTH-1:0] idle_step_s;

  // One shift step of the register pair; returns {A_next, B_next}.
  function automatic logic [2*WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       mode,
    input logic             a_in,
    input logic             b_in
  );
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] a_n;
    logic [WIDTH-1:0] b_n;
    a_msb = 1'b0;
    b_msb = 1'b0;
    a_n   = a;
    b_n   = b;
    if (CHAIN != 0) begin
      // Chained: A's LSB feeds B's MSB; rotate wraps B's LSB back into A's MSB.
      case (mode)
        2'b00:   a_msb = a_in;
        2'b01:   a_msb = a[WIDTH-1];
        2'b10:   a_msb = b[0];
        default: a_msb = 1'b0;
      endcase
      if (mode == 2'b11) begin
        a_n = {a[WIDTH-2:0], b[WIDTH-1]};
        b_n = {b[WIDTH-2:0], b_in};
      end else begin
        a_n = {a_msb, a[WIDTH-1:1]};
        b_n = {a[0], b[WIDTH-1:1]};
      end
    end else begin
      case (mode)
        2'b00: begin
          a_msb = a_in;
          b_msb = b_in;
        end
        2'b01: begin
          a_msb = a[WIDTH-1];
          b_msb = b[WIDTH-1];
        end
        2'b10: begin
          a_msb = a[0];
          b_msb = b[0];
        end
        default: begin
          a_msb = 1'b0;
          b_msb = 1'b0;
        end
      endcase
      if (mode == 2'b11) begin
        a_n = {a[WIDTH-2:0], a_in};
        b_n = {b[WIDTH-2:0], b_in};
      end else begin
        a_n = {a_msb, a[WIDTH-1:1]};
        b_n = {b_msb, b[WIDTH-1:1]};
      end
    end
    return {a_n, b_n};
  endfunction

  assign burst_step_s = shift_step(a_q, b_q, mode_q, A_In, B_In);
  assign idle_step_s  = shift_step(a_q, b_q, Mode, A_In, B_In);

  // Next-state, datapath and status logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          // A zero-length burst still reports completion through DONE.
          if (Count != CNT_ZERO) begin
            state_d = ST_SHIFT;
            cnt_d   = Count;
            mode_d  = Mode;
          end else begin
            state_d = ST_DONE;
          end
        end else if (Ld_A || Ld_B) begin
          if (Ld_A) begin
            a_d = D;
          end else begin
            a_d = a_q;
          end
          if (Ld_B) begin
            b_d = D;
          end else begin
            b_d = b_q;
          end
        end else if (Shift_En) begin
          {a_d, b_d} = idle_step_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        {a_d, b_d} = burst_step_s;
        cnt_d      = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == ST_SHIFT) || (state_d == ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // State, counter, captured mode, data registers and status flags.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      mode_q  <= 2'b00;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign A_out = a_q[0];
  assign B_out = b_q[0];
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_register_unit_burst.sv
// Self-checking bench for register_unit_burst. Drives one stimulus stream into a
// chained (CHAIN=1) and an independent (CHAIN=0) instance and checks both against
// a cycle-level behavioural model, plus hand-computed literal checkpoints.
module tb_register_unit_burst;

  localparam int W  = 8;
  localparam int CW = $clog2(W*2+1);

  logic          clk;
  logic          reset_n;
  logic          ld_a, ld_b, shift_en, start, a_in, b_in;
  logic [W-1:0]  d;
  logic [CW-1:0] count;
  logic [1:0]    mode;

  logic         a_out_c, b_out_c, busy_c, done_c;
  logic [W-1:0] a_c, b_c;
  logic         a_out_n, b_out_n, busy_n, done_n;
  logic [W-1:0] a_n, b_n;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  register_unit_burst #(.WIDTH(W), .CHAIN(1)) dut_c (
    .Clk(clk), .Reset(reset_n), .Ld_A(ld_a), .Ld_B(ld_b), .D(d),
    .Shift_En(shift_en), .Start(start), .Count(count), .Mode(mode),
    .A_In(a_in), .B_In(b_in), .A_out(a_out_c), .B_out(b_out_c),
    .A(a_c), .B(b_c), .Busy(busy_c), .Done(done_c)
  );

  register_unit_burst #(.WIDTH(W), .CHAIN(0)) dut_n (
    .Clk(clk), .Reset(reset_n), .Ld_A(ld_a), .Ld_B(ld_b), .D(d),
    .Shift_En(shift_en), .Start(start), .Count(count), .Mode(mode),
    .A_In(a_in), .B_In(b_in), .A_out(a_out_n), .B_out(b_out_n),
    .A(a_n), .B(b_n), .Busy(busy_n), .Done(done_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // index 0 = chained instance, 1 = independent instance
  logic [W-1:0] m_a [2];
  logic [W-1:0] m_b [2];
  logic [1:0]   m_mode;
  int           busy_left;    // cycles of Busy still to be shown
  int           shifts_left;  // shifts of the burst still to be applied

  // Shift the pair arithmetically; chained pair treated as one 16-bit word.
  function automatic logic [2*W-1:0] mshift(input int chain, input logic [W-1:0] a,
      input logic [W-1:0] b, input logic [1:0] md, input logic ai, input logic bi);
    logic [2*W-1:0] v;
    logic [W-1:0]   ra, rb;
    if (chain != 0) begin
      v = {a, b};
      if (md == 2'd3)      v = (v << 1) | 16'(bi);
      else if (md == 2'd0) v = (v >> 1) | (16'(ai) << (2*W-1));
      else if (md == 2'd1) v = (v >> 1) | (v & 16'h8000);
      else                 v = (v >> 1) | (16'(v[0]) << (2*W-1));
      return v;
    end
    if (md == 2'd3) begin
      ra = (a << 1) | 8'(ai);
      rb = (b << 1) | 8'(bi);
    end else if (md == 2'd0) begin
      ra = (a >> 1) | (8'(ai) << (W-1));
      rb = (b >> 1) | (8'(bi) << (W-1));
    end else if (md == 2'd1) begin
      ra = (a >> 1) | (a & 8'h80);
      rb = (b >> 1) | (b & 8'h80);
    end else begin
      ra = (a >> 1) | (8'(a[0]) << (W-1));
      rb = (b >> 1) | (8'(b[0]) << (W-1));
    end
    return {ra, rb};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin m_a[c] = '0; m_b[c] = '0; end
      m_mode = 2'd0; busy_left = 0; shifts_left = 0;
    end else if (busy_left > 0) begin
      if (shifts_left > 0) begin
        for (int c = 0; c < 2; c++) {m_a[c], m_b[c]} = mshift(c == 0, m_a[c], m_b[c], m_mode, a_in, b_in);
        shifts_left--;
      end
      busy_left--;
    end else if (start) begin
      busy_left = int'(count) + 1; shifts_left = int'(count); m_mode = mode;
    end else if (ld_a || ld_b) begin
      for (int c = 0; c < 2; c++) begin
        if (ld_a) m_a[c] = d;
        if (ld_b) m_b[c] = d;
      end
    end else if (shift_en) begin
      for (int c = 0; c < 2; c++) {m_a[c], m_b[c]} = mshift(c == 0, m_a[c], m_b[c], mode, a_in, b_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_chain", {12'd0, a_c, b_c, a_out_c, b_out_c, busy_c, done_c},
          {12'd0, m_a[0], m_b[0], m_a[0][0], m_b[0][0], busy_left > 0, busy_left == 1});
      chk("model_indep", {12'd0, a_n, b_n, a_out_n, b_out_n, busy_n, done_n},
          {12'd0, m_a[1], m_b[1], m_a[1][0], m_b[1][0], busy_left > 0, busy_left == 1});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    ld_a = 1'b0; ld_b = 1'b0; shift_en = 1'b0; start = 1'b0;
    a_in = 1'b0; b_in = 1'b0; d = '0; count = '0; mode = 2'd0;
  endtask

  task automatic load(input logic [W-1:0] av, input logic [W-1:0] bv);
    ld_a = 1'b1; d = av; step(); ld_a = 1'b0;
    ld_b = 1'b1; d = bv; step(); ld_b = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_at, done_cnt;
    // Reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_a = 1'($urandom); ld_b = 1'($urandom); shift_en = 1'($urandom);
      start = 1'($urandom); a_in = 1'($urandom); b_in = 1'($urandom);
      d = 8'($urandom); count = 5'($urandom); mode = 2'($urandom);
      step();
    end
    check_en = 1'b1;
    chk("reset_status", {30'd0, busy_c, done_c}, 32'd0);
    reset_n = 1'b1;
    idle_inputs();
    step();
    chk("reset_A", {24'd0, a_c}, 32'h00);
    chk("reset_B", {24'd0, b_c}, 32'h00);
    chk("reset_busy_done", {30'd0, busy_c, done_c}, 32'd0);

    // Arithmetic right burst of 4 on the chained pair
    load(8'h81, 8'h00);
    start = 1'b1; count = 5'd4; mode = 2'b01; step();
    start = 1'b0; mode = 2'b10; a_in = 1'b1;
    busy_cnt = 0; done_at = -1;
    for (int i = 1; i <= 8; i++) begin
      if (busy_c) busy_cnt++;
      if (done_c) done_at = i;
      step();
    end
    chk("asr_A", {24'd0, a_c}, 32'hF8);
    chk("asr_B", {24'd0, b_c}, 32'h10);
    chk("asr_busy_cycles", busy_cnt, 32'd5);
    chk("asr_done_cycle", done_at, 32'd5);

    // Rotate the full 16-bit path back to its start
    idle_inputs();
    load(8'h12, 8'h34);
    start = 1'b1; count = 5'd16; mode = 2'b10; step();
    start = 1'b0; mode = 2'b00;
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done_c) done_cnt++;
      step();
    end
    chk("rot_A", {24'd0, a_c}, 32'h12);
    chk("rot_B", {24'd0, b_c}, 32'h34);
    chk("rot_done_pulses", done_cnt, 32'd1);

    // Idle single left shift, then load beats shift
    idle_inputs();
    load(8'h00, 8'h80);
    mode = 2'b11; b_in = 1'b1; shift_en = 1'b1; step();
    chk("lsl_A", {24'd0, a_c}, 32'h01);
    chk("lsl_B", {24'd0, b_c}, 32'h01);
    ld_a = 1'b1; d = 8'h55; step();
    chk("ld_over_shift_A", {24'd0, a_c}, 32'h55);
    chk("ld_over_shift_B", {24'd0, b_c}, 32'h01);
    shift_en = 1'b0; ld_b = 1'b1; d = 8'h3C; step();
    chk("ld_both", {16'd0, a_c, b_c}, 32'h3C3C);

    // Zero-length burst; loads in the same cycle are ignored
    idle_inputs();
    start = 1'b1; count = 5'd0; ld_a = 1'b1; d = 8'hAA; step();
    idle_inputs();
    chk("cnt0_status", {30'd0, busy_c, done_c}, 32'd3);
    chk("cnt0_regs", {16'd0, a_c, b_c}, 32'h3C3C);
    step();
    chk("cnt0_after", {30'd0, busy_c, done_c}, 32'd0);

    // Mid-burst load ignored, then reset aborts the burst
    load(8'h0F, 8'hF0);
    start = 1'b1; count = 5'd8; mode = 2'b00; a_in = 1'b1; step();
    start = 1'b0; step(); step();
    ld_a = 1'b1; d = 8'hFF; step();
    ld_a = 1'b0;
    chk("midburst_A", {24'd0, a_c}, 32'hE1);
    reset_n = 1'b0; step();
    reset_n = 1'b1;
    chk("abort_regs", {14'd0, a_c, b_c, busy_c, done_c}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_c) done_cnt++;
      step();
    end
    chk("abort_no_done", done_cnt, 32'd0);

    // Independent registers, logical right by 2
    idle_inputs();
    load(8'h00, 8'hFF);
    start = 1'b1; count = 5'd2; mode = 2'b00; a_in = 1'b1; b_in = 1'b0; step();
    start = 1'b0; step(); step();
    chk("indep_A", {24'd0, a_n}, 32'hC0);
    chk("indep_B", {24'd0, b_n}, 32'h3F);
    chk("indep_done", {30'd0, busy_n, done_n}, 32'd3);
    step();

    // Count beyond 2*WIDTH saturates to the fill bit
    idle_inputs();
    load(8'hA5, 8'h5A);
    start = 1'b1; count = 5'd20; mode = 2'b00; step();
    start = 1'b0;
    for (int i = 0; i < 22; i++) step();
    chk("long_chain", {16'd0, a_c, b_c}, 32'h0000);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
